// File: rtl/pulse_pkg.sv
// Shared types and constants for the pulse-shape accumulator: FSM state
// encoding, Fibonacci LFSR tap masks, BRAM word size and a default shape.
package pulse_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PICK,
    S_RD,
    S_WAIT,
    S_WR,
    S_NEXT,
    S_DONE
  } state_t;

  localparam int unsigned BYTES_PER_WORD = 4;

  localparam int unsigned DEFAULT_SHAPE_LEN = 4;
  localparam logic [15:0] DEFAULT_SHAPE [DEFAULT_SHAPE_LEN] = '{16'd1, 16'd2, 16'd3, 16'd4};

  // Maximal-length tap masks; bit (e-1) set for every polynomial term x^e.
  function automatic logic [15:0] lfsr_taps(input int w);
    logic [15:0] t;
    case (w)
      8:       t = 16'h00B8;  // x^8+x^6+x^5+x^4+1
      9:       t = 16'h0110;  // x^9+x^5+1
      10:      t = 16'h0240;  // x^10+x^7+1
      11:      t = 16'h0500;  // x^11+x^9+1
      12:      t = 16'h0829;  // x^12+x^6+x^4+x+1
      13:      t = 16'h100D;  // x^13+x^4+x^3+x+1
      14:      t = 16'h2015;  // x^14+x^5+x^3+x+1
      15:      t = 16'h6000;  // x^15+x^14+1
      16:      t = 16'hD008;  // x^16+x^15+x^13+x^4+1
      default: t = 16'h0000;
    endcase
    return t;
  endfunction

  // One Fibonacci step: shift left, XOR of tapped bits enters at bit 0.
  // Bits above the register width are discarded by the caller.
  function automatic logic [15:0] lfsr_step(input logic [15:0] q, input int w);
    return {q[14:0], ^(q & lfsr_taps(w))};
  endfunction

endpackage

// File: rtl/pulse_lfsr.sv
// Fibonacci LFSR used to pick a pseudo-random base address per pulse.
// A zero seed is replaced by 1 so the register can never lock up.
module pulse_lfsr
  import pulse_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             step,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Load has priority over step; reset value is the non-zero state 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= ONE;
    end else if (load) begin
      value <= (seed == '0) ? ONE : seed;
    end else if (step) begin
      value <= WIDTH'(lfsr_step(16'(value), WIDTH));
    end
  end

endmodule

// File: rtl/pulse_shape_accum.sv
// Pulse-shape accumulator: for each of cps pulses, pick a random base via
// the LFSR, mark it in the pin buffer, then read-modify-write PULSE_LEN
// consecutive shape-buffer words (wrapping) with the shape table samples.
module pulse_shape_accum
  import pulse_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int PULSE_LEN = 50,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       cps,
  input  logic [ADDR_W-1:0] seed,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  input  logic              tbl_we,
  input  logic [7:0]        tbl_addr,
  input  logic [DATA_W-1:0] tbl_wdata,
  output logic              pin_en,
  output logic              pin_we,
  output logic [31:0]       pin_addr,
  output logic [31:0]       pin_wdata,
  output logic              buf_en,
  output logic              buf_we,
  output logic [31:0]       buf_addr,
  output logic [DATA_W-1:0] buf_wdata,
  input  logic [DATA_W-1:0] buf_rdata
);

  localparam int         IDX_W    = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [7:0] LAST_IDX = 8'(PULSE_LEN - 1);

  state_t              state_q, state_n;
  logic [31:0]         cps_q, pcnt_q;
  logic [7:0]          idx_q;
  logic [ADDR_W-1:0]   base_q, lfsr_val, lfsr_nxt, samp_addr;
  logic                mode_q, busy_q;
  logic [DATA_W-1:0]   tbl_q;
  logic [DATA_W-1:0]   shape_tbl [PULSE_LEN];
  logic                kill, go, lfsr_load, lfsr_step_en;

  function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
  endfunction

  assign kill         = abort && (state_q != S_IDLE);
  assign go           = (state_q == S_IDLE) && start && !abort;
  assign lfsr_load    = go && (cps != '0);
  assign lfsr_step_en = (state_q == S_PICK);
  assign lfsr_nxt     = ADDR_W'(lfsr_step(16'(lfsr_val), ADDR_W));
  assign samp_addr    = base_q + ADDR_W'(idx_q);
  assign busy         = busy_q;

  pulse_lfsr #(.WIDTH(ADDR_W)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (seed),
    .step  (lfsr_step_en),
    .value (lfsr_val)
  );

  // State register plus burst bookkeeping (counters, base, latched controls).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      cps_q   <= '0;
      pcnt_q  <= '0;
      idx_q   <= '0;
      base_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      if (kill) begin
        busy_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (lfsr_load) begin
            cps_q  <= cps;
            pcnt_q <= '0;
            idx_q  <= '0;
            mode_q <= mode;
            busy_q <= 1'b1;
          end
          S_PICK:  base_q <= lfsr_nxt;
          S_WR:    idx_q  <= (idx_q == LAST_IDX) ? 8'd0 : idx_q + 8'd1;
          S_NEXT:  pcnt_q <= pcnt_q + 32'd1;
          S_DONE:  busy_q <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  // Next-state: one PICK, PULSE_LEN x (RD, WAIT, WR), one NEXT per pulse.
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (go) state_n = (cps != '0) ? S_PICK : S_DONE;
      S_PICK:  state_n = S_RD;
      S_RD:    state_n = S_WAIT;
      S_WAIT:  state_n = S_WR;
      S_WR:    state_n = (idx_q == LAST_IDX) ? S_NEXT : S_RD;
      S_NEXT:  state_n = (pcnt_q + 32'd1 == cps_q) ? S_DONE : S_PICK;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (kill) state_n = S_IDLE;
  end

  // BRAM controls decoded purely from the current state; idle drives zeros.
  always_comb begin
    pin_en    = 1'b0;
    pin_we    = 1'b0;
    pin_addr  = '0;
    pin_wdata = '0;
    buf_en    = 1'b0;
    buf_we    = 1'b0;
    buf_addr  = '0;
    buf_wdata = '0;
    done      = 1'b0;
    case (state_q)
      S_PICK: begin
        pin_en    = 1'b1;
        pin_we    = 1'b1;
        pin_addr  = 32'(lfsr_nxt) * BYTES_PER_WORD;
        pin_wdata = 32'd1;
      end
      S_RD: begin
        buf_en   = 1'b1;
        buf_addr = 32'(samp_addr) * BYTES_PER_WORD;
      end
      S_WR: begin
        buf_en    = 1'b1;
        buf_we    = 1'b1;
        buf_addr  = 32'(samp_addr) * BYTES_PER_WORD;
        buf_wdata = mode_q ? sat_add(buf_rdata, tbl_q) : tbl_q;
      end
      S_DONE:  done = !abort;
      default: ;
    endcase
  end

  // Shape table: writable only while idle, out-of-range indices dropped.
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && tbl_we && (int'(tbl_addr) < PULSE_LEN)) begin
      shape_tbl[tbl_addr[IDX_W-1:0]] <= tbl_wdata;
    end
  end

  // Sample for the current index, captured while the buffer read settles.
  always_ff @(posedge clk) begin
    if (state_q == S_WAIT) begin
      tbl_q <= shape_tbl[idx_q[IDX_W-1:0]];
    end
  end

endmodule

// File: tb/tb_pulse_shape_accum.sv
// Bench for pulse_shape_accum: BRAM model, reference model of the burst
// rules, and a scoreboard monitor comparing every pin and buffer write.
module tb_pulse_shape_accum;
  import pulse_pkg::*;

  localparam int PL = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, mode_i, tbl_we;
  logic [31:0] cps_i;
  logic [9:0]  seed_i;
  logic [7:0]  tbl_addr;
  logic [15:0] tbl_wdata;
  logic        busy, done, pin_en, pin_we, buf_en, buf_we;
  logic [31:0] pin_addr, pin_wdata, buf_addr;
  logic [15:0] buf_wdata;
  logic [15:0] buf_rdata = 16'h0;

  logic [15:0] bram    [1024] = '{default: 16'h0};
  logic [15:0] mem_ref [1024] = '{default: 16'h0};
  logic        poke_en = 1'b0;
  logic [9:0]  poke_addr = 10'd0;
  logic [15:0] poke_data = 16'h0;

  typedef struct { int unsigned addr; int unsigned data; } wr_t;
  wr_t         exp_q[$];
  int unsigned pin_q[$];
  int unsigned tbl_ref [PL];

  int checks = 0, errors = 0;
  int en_cnt = 0, done_cnt = 0;

  always #5 clk = ~clk;

  pulse_shape_accum #(.ADDR_W(10), .PULSE_LEN(PL), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cps(cps_i),
    .seed(seed_i), .mode(mode_i), .busy(busy), .done(done),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .pin_en(pin_en), .pin_we(pin_we), .pin_addr(pin_addr), .pin_wdata(pin_wdata),
    .buf_en(buf_en), .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata), .buf_rdata(buf_rdata)
  );

  // Shape BRAM: registered read output that holds while not enabled.
  always @(posedge clk) begin
    if (poke_en) bram[poke_addr] <= poke_data;
    else if (buf_en && buf_we) bram[buf_addr[11:2]] <= buf_wdata;
    if (buf_en && !buf_we) buf_rdata <= bram[buf_addr[11:2]];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    wr_t e;
    int unsigned pa;
    if (pin_en || buf_en) en_cnt++;
    if (done) done_cnt++;
    if (buf_en && buf_we) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL buf_wr_extra: write addr %0h data %0h, none expected", buf_addr, buf_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("buf_wr_addr", 128'(buf_addr), 128'(e.addr));
        chk("buf_wr_data", 128'(buf_wdata), 128'(e.data));
      end
    end
    if (pin_en && pin_we) begin
      if (pin_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pin_wr_extra: write addr %0h, none expected", pin_addr);
      end else begin
        pa = pin_q.pop_front();
        chk("pin_wr_addr", 128'(pin_addr), 128'(pa));
        chk("pin_wr_data", 128'(pin_wdata), 128'd1);
      end
    end
  end

  // x^10 + x^7 + 1, new bit enters at the bottom.
  function automatic int unsigned lfsr_adv(input int unsigned s);
    int unsigned fb;
    fb = ((s >> 9) ^ (s >> 6)) & 1;
    return ((s << 1) | fb) & 1023;
  endfunction

  // Reference: expected writes of a burst, cut off after maxw buffer writes.
  task automatic model_burst(input int unsigned c, input int unsigned sd, input bit md, input int maxw);
    int unsigned s;
    int nw = 0;
    s = (sd == 0) ? 1 : sd;
    for (int p = 0; p < int'(c); p++) begin
      if (nw >= maxw) break;
      s = lfsr_adv(s);
      pin_q.push_back(s * 4);
      for (int i = 0; i < PL; i++) begin
        int unsigned a, v;
        if (nw >= maxw) break;
        a = (s + i) % 1024;
        v = md ? 32'(mem_ref[a]) + tbl_ref[i] : tbl_ref[i];
        if (v > 65535) v = 65535;
        mem_ref[a] = 16'(v);
        exp_q.push_back('{addr: a * 4, data: v});
        nw++;
      end
    end
  endtask

  task automatic load_tbl();
    for (int i = 0; i < PL; i++) begin
      @(negedge clk);
      tbl_we = 1'b1; tbl_addr = 8'(i); tbl_wdata = 16'(tbl_ref[i]);
    end
    @(negedge clk);
    tbl_we = 1'b0;
  endtask

  task automatic poke(input int unsigned a, input logic [15:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = 10'(a); poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
    mem_ref[a] = d;
  endtask

  // Returns at the first negedge after the edge that samples start.
  task automatic start_burst(input int unsigned c, input int unsigned sd, input bit md);
    @(negedge clk);
    cps_i = c; seed_i = 10'(sd); mode_i = md; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (c != 0) chk("busy_set", 128'(busy), 128'd1);
  endtask

  task automatic wait_done(input string name, input int n0, input int expn);
    int n = n0;
    while (done !== 1'b1 && n < expn + 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_latency"}, 128'(n), 128'(expn));
    @(negedge clk);
    chk({name, "_done_one_cycle"}, 128'(done), 128'd0);
    chk({name, "_busy_clear"}, 128'(busy), 128'd0);
    chk({name, "_all_writes_seen"}, 128'(exp_q.size() + pin_q.size()), 128'd0);
  endtask

  task automatic chk_outs_zero(input string name);
    chk(name, 128'({busy, done, pin_en, pin_we, pin_addr, pin_wdata,
                    buf_en, buf_we, buf_addr, buf_wdata}), 128'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, d0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode_i = 1'b0; tbl_we = 1'b0;
    cps_i = '0; seed_i = '0; tbl_addr = '0; tbl_wdata = '0;
    #3;
    chk_outs_zero("reset_outputs");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Default ramp shape, single pulse, seed 5 -> base 10.
    for (int i = 0; i < PL; i++) tbl_ref[i] = 32'(DEFAULT_SHAPE[i]);
    load_tbl();
    model_burst(1, 5, 1'b1, 1000);
    start_burst(1, 5, 1'b1);
    wait_done("ramp1", 0, 14);
    chk("ramp1_w10", 128'(bram[10]), 128'd1);
    chk("ramp1_w13", 128'(bram[13]), 128'd4);

    // Same seed again accumulates.
    model_burst(1, 5, 1'b1, 1000);
    start_burst(1, 5, 1'b1);
    wait_done("ramp2", 0, 14);
    chk("ramp2_w10", 128'(bram[10]), 128'd2);
    chk("ramp2_w13", 128'(bram[13]), 128'd8);

    // Seed 1023 steps to base 1022: samples wrap to words 0 and 1.
    model_burst(1, 1023, 1'b0, 1000);
    start_burst(1, 1023, 1'b0);
    wait_done("wrap", 0, 14);
    chk("wrap_w1022", 128'(bram[1022]), 128'd1);
    chk("wrap_w1023", 128'(bram[1023]), 128'd2);
    chk("wrap_w0", 128'(bram[0]), 128'd3);
    chk("wrap_w1", 128'(bram[1]), 128'd4);

    // Saturation, then overwrite mode.
    for (int i = 0; i < PL; i++) tbl_ref[i] = 5;
    load_tbl();
    poke(10, 16'hFFFE);
    model_burst(1, 5, 1'b1, 1000);
    start_burst(1, 5, 1'b1);
    wait_done("sat", 0, 14);
    chk("sat_w10", 128'(bram[10]), 128'hFFFF);
    model_burst(1, 5, 1'b0, 1000);
    start_burst(1, 5, 1'b0);
    wait_done("ovw", 0, 14);
    chk("ovw_w10", 128'(bram[10]), 128'd5);

    // cps = 0: done right away, no BRAM activity.
    e0 = en_cnt;
    start_burst(0, 9, 1'b1);
    chk("cps0_busy", 128'(busy), 128'd0);
    wait_done("cps0", 0, 0);
    chk("cps0_no_en", 128'(en_cnt - e0), 128'd0);

    // abort beats start in the same idle cycle.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; cps_i = 32'd2;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", 128'(busy), 128'd0);
    e0 = en_cnt; d0 = done_cnt;
    repeat (5) @(negedge clk);
    chk("abort_start_no_en", 128'(en_cnt - e0), 128'd0);
    chk("abort_start_no_done", 128'(done_cnt - d0), 128'd0);

    // start and tbl_we while busy are ignored.
    model_burst(2, 321, 1'b1, 1000);
    start_burst(2, 321, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1; cps_i = 32'd7; seed_i = 10'd99;
    tbl_we = 1'b1; tbl_addr = 8'd0; tbl_wdata = 16'h1234;
    @(negedge clk);
    start = 1'b0; tbl_we = 1'b0;
    wait_done("busy_ignore", 6, 28);

    // Out-of-range table index is dropped; overwrite burst exposes the table.
    @(negedge clk);
    tbl_we = 1'b1; tbl_addr = 8'(PL); tbl_wdata = 16'h0777;
    @(negedge clk);
    tbl_we = 1'b0;
    model_burst(1, 77, 1'b0, 1000);
    start_burst(1, 77, 1'b0);
    wait_done("tbl_oor", 0, 14);

    // Randomized bursts, first one with a zero seed.
    for (int r = 0; r < 6; r++) begin
      int unsigned c, sd;
      bit md;
      for (int i = 0; i < PL; i++)
        tbl_ref[i] = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 65535) : $urandom_range(0, 300);
      load_tbl();
      c  = $urandom_range(1, 3);
      sd = (r == 0) ? 0 : $urandom_range(0, 1023);
      md = 1'($urandom_range(0, 1));
      model_burst(c, sd, md, 1000);
      start_burst(c, sd, md);
      wait_done("rand", 0, int'(c) * 14);
    end

    // Abort in the second pulse while its second write is on the bus.
    model_burst(3, 200, 1'b1, 6);
    start_burst(3, 200, 1'b1);
    repeat (20) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy_drop", 128'(busy), 128'd0);
    chk("abort_no_done", 128'(done), 128'd0);
    chk("abort_en_drop", 128'({pin_en, buf_en}), 128'd0);
    e0 = en_cnt; d0 = done_cnt;
    repeat (40) @(negedge clk);
    chk("abort_quiet_en", 128'(en_cnt - e0), 128'd0);
    chk("abort_quiet_done", 128'(done_cnt - d0), 128'd0);
    chk("abort_writes_seen", 128'(exp_q.size() + pin_q.size()), 128'd0);

    // Asynchronous reset in the middle of a read.
    model_burst(3, 444, 1'b1, 3);
    start_burst(3, 444, 1'b1);
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_outs_zero("midburst_reset_outputs");
    chk("reset_writes_seen", 128'(exp_q.size() + pin_q.size()), 128'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Recovery after reset.
    for (int i = 0; i < PL; i++) tbl_ref[i] = 32'(DEFAULT_SHAPE[i]) * 3;
    load_tbl();
    model_burst(2, 17, 1'b1, 1000);
    start_burst(2, 17, 1'b1);
    wait_done("post_reset", 0, 28);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_shape_accum.md
PULSE_SHAPE_ACCUM -- requirements
Module: pulse_shape_accum

Interface
REQ-001 Parameter ADDR_W, default 10: shape buffer and pin buffer depth is 2**ADDR_W words; LFSR width equals ADDR_W.
REQ-002 Parameter PULSE_LEN, default 50: samples per pulse shape, legal range 1..256.
REQ-003 Parameter DATA_W, default 32: sample and accumulator width, unsigned fixed point.
REQ-004 Ports:
 - clk  in  1  single clock; all logic on rising edge.
 - rst_n  in  1  asynchronous, active-low reset.
 - start  in  1  one-cycle request to run a burst.
 - abort  in  1  synchronous cancel of the current burst.
 - cps  in  32  pulse count for the burst.
 - seed  in  ADDR_W  LFSR seed.
 - mode  in  1  1 = accumulate into the buffer, 0 = overwrite the buffer.
 - busy  out  1  burst in progress.
 - done  out  1  one-cycle burst-complete strobe.
 - tbl_we  in  1  shape table write strobe.
 - tbl_addr  in  8  shape table index.
 - tbl_wdata  in  DATA_W  shape table sample.
 - pin_en, pin_we  out  1 each  pin BRAM enable and write enable.
 - pin_addr  out  32  pin BRAM byte address.
 - pin_wdata  out  32  pin BRAM write data.
 - buf_en, buf_we  out  1 each  shape BRAM enable and write enable.
 - buf_addr  out  32  shape BRAM byte address.
 - buf_wdata  out  DATA_W  shape BRAM write data.
 - buf_rdata  in  DATA_W  shape BRAM read data; valid one cycle after a read.

Function
REQ-005 The FSM states shall be IDLE, PICK, RD, WAIT, WR, NEXT and DONE; the state register shall be the only path that drives BRAM controls.
REQ-006 In IDLE, start=1 with cps!=0 shall do the following, then go to PICK:
 - latch cps;
 - load the LFSR with seed, or with 1 when seed is 0;
 - clear the pulse counter and sample index;
 - set busy.
REQ-007 In IDLE, start=1 with cps==0 shall go directly to DONE with no BRAM access.
REQ-008 start shall be ignored outside IDLE.
REQ-009 PICK shall advance the LFSR one step and latch base = the new LFSR value. The LFSR is a Fibonacci LFSR with taps from the package table; for ADDR_W=10 the polynomial is x^10+x^7+1.
REQ-010 PICK shall issue one pin write: pin_en=1, pin_we=1, pin_addr=base*4, pin_wdata=1.
REQ-011 RD shall drive buf_en=1, buf_we=0, buf_addr=((base+idx) mod 2**ADDR_W)*4. Address wrap-around is mandatory.
REQ-012 WAIT shall drive buf_en=0 and register table[idx].
REQ-013 WR shall drive buf_en=1, buf_we=1 at the same address as RD.
 - mode=1: buf_wdata = buf_rdata + table[idx], saturating at 2**DATA_W-1.
 - mode=0: buf_wdata = table[idx].
REQ-014 After WR, the FSM shall go to RD with idx+1 if idx<PULSE_LEN-1; otherwise it shall clear idx and go to NEXT.
REQ-015 NEXT shall increment the pulse counter, then go to DONE when the count reaches the latched cps, else go to PICK.
REQ-016 DONE shall assert done=1 for exactly one cycle, clear busy and return to IDLE.
REQ-017 Each pulse shall take exactly 3*PULSE_LEN+2 cycles. done shall rise cps*(3*PULSE_LEN+2) cycles after the edge that samples start.
REQ-018 abort=1 in any non-IDLE state shall go to IDLE on the next edge, drop all enables, clear busy and not assert done. A BRAM write in flight on that cycle completes; no further write is issued.
REQ-019 abort takes priority over start when both are high in the same cycle.
REQ-020 tbl_we shall write the table only in IDLE; it is ignored while busy and when tbl_addr>=PULSE_LEN.
REQ-021 All enables shall be 0 in every state not named above as driving them.

Reset
REQ-022 rst_n=0 shall immediately force:
 - state=IDLE;
 - busy=0, done=0;
 - all en/we=0;
 - addresses and wdata=0;
 - LFSR=1, counters=0.
REQ-023 Table contents shall be undefined after reset. The table is not reset, so it maps to distributed RAM.

Structure
REQ-024 Package pulse_pkg shall hold the state enumeration, the LFSR tap table indexed by width 8..16, the BYTES_PER_WORD=4 constant and the default pulse-shape values.
REQ-025 The LFSR shall be a sub-module named pulse_lfsr, parametrised by width, with ports load, seed, step and value.

Verification
REQ-026 With PULSE_LEN=4, DATA_W=16, a zeroed buffer, mode=1, table={1,2,3,4}, seed=5 and cps=1: four RD/WR pairs at consecutive addresses from base, written values 1,2,3,4, and done exactly 14 cycles after start.
REQ-027 Repeat REQ-026 on the same buffer with the same seed: written values 2,4,6,8, proving accumulation.
REQ-028 Force base=2**ADDR_W-2: sample addresses 1022,1023,0,1 (×4) for ADDR_W=10.
REQ-029 Set a buffer word to 0xFFFE and the table to 5: the written value is 0xFFFF (saturated). With mode=0, the written value is 5.
REQ-030 Run cps=3, assert abort on cycle 20, then drop rst_n mid-burst:
 - after abort: busy falls next cycle, no done, no writes afterwards;
 - on reset: all outputs are 0 asynchronously.
REQ-031 Pulse start=1 with cps=0: done one cycle later, no en activity. A start during busy, or a tbl_we during busy, leaves the result unchanged.
